// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data RAM.
// slave  : arbiter side (takes requests, drives the RAM).
// master : requester/RAM-model side.
interface data_mem_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic          req0,   req1;
    logic          we0,    we1;
    logic [AW-1:0] addr0,  addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0,   gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          busy;
    logic [15:0]   conflict_cnt;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               ram_we, ram_addr, ram_din, busy, conflict_cnt
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               ram_we, ram_addr, ram_din, busy, conflict_cnt
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous data RAM.
// Port 0 = CPU load/store, port 1 = debug/loader. One transaction at a time:
// IDLE (arbitrate/latch) -> ISSUE (drive RAM, gnt) -> WAIT (read latency) -> IDLE.
// Build option: define DMARB_RR_EN for round-robin on ties; otherwise port 0
// always wins ties.
module data_mem_arbiter #(
    parameter int AW     = 6,
    parameter int DW     = 32,
    parameter int RD_LAT = 1     // 1..3
) (
    input logic               clk,
    input logic               rst,   // async, active low
    data_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // WAIT counts down from here; the RAM output is captured when it reaches 0
    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_t        state_q, state_d;
    logic          win_q;      // latched winner: 0 = port 0, 1 = port 1
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [1:0]    lat_q;
    logic [15:0]   cnt_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    logic any_req, both_req, pick1, lat_done, rv0, rv1;

    assign any_req  = bus.req0 | bus.req1;
    assign both_req = bus.req0 & bus.req1;

`ifdef DMARB_RR_EN
    logic last_gnt_q;

    // Round-robin: on a tie the port that did not win last time goes next
    always_comb pick1 = bus.req1 && (!bus.req0 || !last_gnt_q);
`else
    // Fixed priority: port 1 only wins when port 0 is not asking
    always_comb pick1 = bus.req1 && !bus.req0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = we_q ? IDLE : WAIT;
            WAIT:    if (lat_q == 2'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, latency counter, conflict counter and read-data hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lat_q    <= 2'd0;
            cnt_q    <= 16'd0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef DMARB_RR_EN
            last_gnt_q <= 1'b1;   // makes port 0 the first tie winner
`endif
        end else begin
            if (state_q == IDLE && any_req) begin
                win_q   <= pick1;
                we_q    <= pick1 ? bus.we1    : bus.we0;
                addr_q  <= pick1 ? bus.addr1  : bus.addr0;
                wdata_q <= pick1 ? bus.wdata1 : bus.wdata0;
`ifdef DMARB_RR_EN
                last_gnt_q <= pick1;
`endif
                if (both_req && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            end
            if (state_q == ISSUE && !we_q)            lat_q <= LAT_INIT;
            else if (state_q == WAIT && lat_q != 2'd0) lat_q <= lat_q - 2'd1;
            if (rv0) rdata0_q <= bus.ram_dout;
            if (rv1) rdata1_q <= bus.ram_dout;
        end
    end

    // Read data is valid in the last WAIT cycle; pass it straight through
    // then and keep the captured copy afterwards.
    assign lat_done = (state_q == WAIT) && (lat_q == 2'd0);
    assign rv0      = lat_done && !win_q;
    assign rv1      = lat_done &&  win_q;

    assign bus.gnt0         = (state_q == ISSUE) && !win_q;
    assign bus.gnt1         = (state_q == ISSUE) &&  win_q;
    assign bus.rvalid0      = rv0;
    assign bus.rvalid1      = rv1;
    assign bus.rdata0       = rv0 ? bus.ram_dout : rdata0_q;
    assign bus.rdata1       = rv1 ? bus.ram_dout : rdata1_q;
    assign bus.ram_we       = (state_q == ISSUE) && we_q;
    assign bus.ram_addr     = addr_q;
    assign bus.ram_din      = wdata_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: one instance with RD_LAT=1 (u_a) and one with
// RD_LAT=3 (u_c), each with a behavioural RAM. Read expectations go into a
// scoreboard queue when the request is driven and are checked on rvalid.
// Build with or without DMARB_RR_EN; tie-order expectations follow it.
module tb_data_mem_arbiter;

    logic clk, rst_a, rst_c;
    int   tests = 0;
    int   fails = 0;

    data_mem_arbiter_if #(.AW(6), .DW(32)) bus_a ();
    data_mem_arbiter_if #(.AW(6), .DW(32)) bus_c ();

    data_mem_arbiter #(.AW(6), .DW(32), .RD_LAT(1)) u_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
    data_mem_arbiter #(.AW(6), .DW(32), .RD_LAT(3)) u_c (.clk(clk), .rst(rst_c), .bus(bus_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: write on ram_we, read data RD_LAT cycles after the address
    logic [31:0] mem_a [64];
    logic [31:0] mem_c [64];
    logic [31:0] dout_a, p1_c, p2_c, p3_c;

    always @(posedge clk) begin
        if (bus_a.ram_we) mem_a[bus_a.ram_addr] <= bus_a.ram_din;
        dout_a <= mem_a[bus_a.ram_addr];
        if (bus_c.ram_we) mem_c[bus_c.ram_addr] <= bus_c.ram_din;
        p1_c <= mem_c[bus_c.ram_addr];
        p2_c <= p1_c;
        p3_c <= p2_c;
    end
    assign bus_a.ram_dout = dout_a;
    assign bus_c.ram_dout = p3_c;

    typedef struct {
        bit          port;
        bit          we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          idx;    // 2*dut + port
        logic [31:0] d;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic gnt_of(input bit dc, input bit p);
        if (dc) return p ? bus_c.gnt1 : bus_c.gnt0;
        return p ? bus_a.gnt1 : bus_a.gnt0;
    endfunction

    function automatic logic rv_of(input bit dc, input bit p);
        if (dc) return p ? bus_c.rvalid1 : bus_c.rvalid0;
        return p ? bus_a.rvalid1 : bus_a.rvalid0;
    endfunction

    function automatic logic busy_of(input bit dc);
        return dc ? bus_c.busy : bus_a.busy;
    endfunction

    function automatic logic [15:0] cnt_of(input bit dc);
        return dc ? bus_c.conflict_cnt : bus_a.conflict_cnt;
    endfunction

    function automatic logic [38:0] ram_of(input bit dc);
        if (dc) return {bus_c.ram_we, bus_c.ram_addr, bus_c.ram_din};
        return {bus_a.ram_we, bus_a.ram_addr, bus_a.ram_din};
    endfunction

    task automatic drive(input bit dc, input bit p, input logic rq, input logic w,
                         input logic [5:0] a, input logic [31:0] d);
        if (!dc && !p)     begin bus_a.req0 = rq; bus_a.we0 = w; bus_a.addr0 = a; bus_a.wdata0 = d; end
        else if (!dc)      begin bus_a.req1 = rq; bus_a.we1 = w; bus_a.addr1 = a; bus_a.wdata1 = d; end
        else if (!p)       begin bus_c.req0 = rq; bus_c.we0 = w; bus_c.addr0 = a; bus_c.wdata0 = d; end
        else               begin bus_c.req1 = rq; bus_c.we1 = w; bus_c.addr1 = a; bus_c.wdata1 = d; end
    endtask

    task automatic wait_idle(input bit dc);
        for (int i = 0; i < 20; i++) begin
            if (!busy_of(dc)) return;
            @(negedge clk);
        end
        chk("idle_timeout", 1'b1, 1'b0);
    endtask

    // One transaction; records gnt/rvalid/busy over 7 cycles from the request
    task automatic txn(input bit dc, input vec_t v, input string nm);
        logic [6:0]  g, go, r, b, rexp, bexp;
        logic [38:0] ram_obs;
        exp_t        e;
        int          lat;
        lat = dc ? 3 : 1;
        wait_idle(dc);
        @(posedge clk); #1;
        drive(dc, v.port, 1'b1, v.we, v.addr, v.wdata);
        if (!v.we) begin
            e.idx = 2 * int'(dc) + int'(v.port);
            e.d   = v.exp;
            sbq.push_back(e);
        end
        ram_obs = '0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            g[k]  = gnt_of(dc, v.port);
            go[k] = gnt_of(dc, !v.port);
            r[k]  = rv_of(dc, v.port);
            b[k]  = busy_of(dc);
            if (k == 1) begin
                ram_obs = ram_of(dc);
                @(posedge clk); #1;
                drive(dc, v.port, 1'b0, 1'b0, 6'd0, 32'd0);
            end
        end
        rexp = v.we ? 7'd0 : 7'(1 << (lat + 1));
        bexp = v.we ? 7'b0000010 : 7'(((1 << (lat + 2)) - 1) & ~1);
        chk({nm, "_gnt"}, g, 7'b0000010);
        chk({nm, "_gnt_other"}, go, 7'd0);
        chk({nm, "_rvalid"}, r, rexp);
        chk({nm, "_busy"}, b, bexp);
        chk({nm, "_ram_we_addr"}, ram_obs[38:32], {v.we, v.addr});
        if (v.we) chk({nm, "_ram_din"}, ram_obs[31:0], v.wdata);
    endtask

    // Both ports request writes together until n grants have been seen
    task automatic conflict(input bit dc, input int n, output logic [3:0] ord, output int got);
        ord = 4'd0;
        got = 0;
        wait_idle(dc);
        @(posedge clk); #1;
        drive(dc, 1'b0, 1'b1, 1'b1, 6'd10, 32'h1111_0000);
        drive(dc, 1'b1, 1'b1, 1'b1, 6'd11, 32'h2222_0000);
        for (int i = 0; i < 40 && got < n; i++) begin
            @(negedge clk);
            if (gnt_of(dc, 1'b0) || gnt_of(dc, 1'b1)) begin
                ord = {ord[2:0], gnt_of(dc, 1'b1)};
                got++;
            end
        end
        @(posedge clk); #1;
        drive(dc, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
        drive(dc, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
    endtask

    // Scoreboard and one-hot checks on both instances
    task automatic mon(input bit dc, input logic g0, input logic g1, input logic v0,
                       input logic v1, input logic [31:0] d0, input logic [31:0] d1);
        exp_t e;
        if (g0 || g1) chk("gnt_exclusive", g0 & g1, 1'b0);
        if (v0 || v1) begin
            chk("rvalid_exclusive", v0 & v1, 1'b0);
            if (sbq.size() == 0) begin
                chk("rvalid_unexpected", 1'b1, 1'b0);
            end else begin
                e = sbq.pop_front();
                chk("sb_port", 2 * int'(dc) + int'(v1), e.idx);
                chk("sb_rdata", v1 ? d1 : d0, e.d);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(1'b0, bus_a.gnt0, bus_a.gnt1, bus_a.rvalid0, bus_a.rvalid1, bus_a.rdata0, bus_a.rdata1);
        mon(1'b1, bus_c.gnt0, bus_c.gnt1, bus_c.rvalid0, bus_c.rvalid1, bus_c.rdata0, bus_c.rdata1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t       vecs [9];
        vec_t       v;
        logic [3:0] ord;
        int         got;
        int         pulses;

        vecs[0] = '{port: 1'b0, we: 1'b1, addr: 6'd5,  wdata: 32'hDEADBEEF, exp: 32'h0};
        vecs[1] = '{port: 1'b1, we: 1'b0, addr: 6'd5,  wdata: 32'h0,        exp: 32'hDEADBEEF};
        vecs[2] = '{port: 1'b1, we: 1'b1, addr: 6'd63, wdata: 32'hA5A50001, exp: 32'h0};
        vecs[3] = '{port: 1'b0, we: 1'b0, addr: 6'd63, wdata: 32'h0,        exp: 32'hA5A50001};
        vecs[4] = '{port: 1'b0, we: 1'b1, addr: 6'd0,  wdata: 32'h12345678, exp: 32'h0};
        vecs[5] = '{port: 1'b1, we: 1'b0, addr: 6'd0,  wdata: 32'h0,        exp: 32'h12345678};
        vecs[6] = '{port: 1'b0, we: 1'b0, addr: 6'd5,  wdata: 32'h0,        exp: 32'hDEADBEEF};
        vecs[7] = '{port: 1'b1, we: 1'b1, addr: 6'd5,  wdata: 32'hCAFEF00D, exp: 32'h0};
        vecs[8] = '{port: 1'b1, we: 1'b0, addr: 6'd5,  wdata: 32'h0,        exp: 32'hCAFEF00D};

        rst_a = 1'b0;
        rst_c = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                drive(d[0], p[0], 1'b0, 1'b0, 6'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("reset_a", {bus_a.gnt0, bus_a.gnt1, bus_a.rvalid0, bus_a.rvalid1, bus_a.busy, bus_a.ram_we,
                        bus_a.ram_addr, bus_a.ram_din, bus_a.conflict_cnt, bus_a.rdata0, bus_a.rdata1}, '0);
        chk("reset_c", {bus_c.gnt0, bus_c.gnt1, bus_c.rvalid0, bus_c.rvalid1, bus_c.busy, bus_c.ram_we,
                        bus_c.ram_addr, bus_c.ram_din, bus_c.conflict_cnt, bus_c.rdata0, bus_c.rdata1}, '0);
        rst_a = 1'b1;
        rst_c = 1'b1;

        // Single-requester vectors on the RD_LAT=1 instance
        for (int i = 0; i < 9; i++) txn(1'b0, vecs[i], $sformatf("vec%0d", i));
        repeat (2) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        chk("rdata0_hold", bus_a.rdata0, 32'hDEADBEEF);
        chk("rdata1_hold", bus_a.rdata1, 32'hCAFEF00D);

        // Four tied arbitrations; last winner before this was port 1
        conflict(1'b0, 4, ord, got);
        chk("tie_grants", got, 4);
`ifdef DMARB_RR_EN
        chk("tie_order", ord, 4'b0101);
`else
        chk("tie_order", ord, 4'b0000);
`endif
        chk("tie_conflict_cnt", bus_a.conflict_cnt, 16'd4);

        // Saturation of the conflict counter
        @(negedge clk);
        force u_a.cnt_q = 16'hFFFE;
        #1;
        release u_a.cnt_q;
        chk("cnt_preset", bus_a.conflict_cnt, 16'hFFFE);
        conflict(1'b0, 2, ord, got);
        chk("sat_grants", got, 2);
        chk("cnt_saturated", bus_a.conflict_cnt, 16'hFFFF);

        // RD_LAT=3 instance: write then read back
        v = '{port: 1'b1, we: 1'b1, addr: 6'd7, wdata: 32'h0BADF00D, exp: 32'h0};
        txn(1'b1, v, "lat3_wr");
        v = '{port: 1'b0, we: 1'b0, addr: 6'd7, wdata: 32'h0, exp: 32'h0BADF00D};
        txn(1'b1, v, "lat3_rd");
        conflict(1'b1, 1, ord, got);
        chk("c_conflict_cnt", bus_c.conflict_cnt, 16'd1);

        // Reset in the middle of WAIT abandons the read
        wait_idle(1'b1);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd7, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_gnt", bus_c.gnt1, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
        @(negedge clk);
        chk("abort_in_wait", bus_c.busy, 1'b1);
        rst_c = 1'b0;
        #1;
        chk("abort_outputs", {bus_c.busy, bus_c.ram_we, bus_c.gnt0, bus_c.gnt1,
                              bus_c.rvalid0, bus_c.rvalid1, bus_c.conflict_cnt}, '0);
        chk("abort_rdata_cleared", bus_c.rdata0, 32'd0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) rst_c = 1'b1;
            if (bus_c.rvalid0 || bus_c.rvalid1) pulses++;
        end
        chk("abort_no_rvalid", pulses, 0);

        // Normal service after the abort
        v = '{port: 1'b1, we: 1'b0, addr: 6'd7, wdata: 32'h0, exp: 32'h0BADF00D};
        txn(1'b1, v, "post_abort_rd");
        repeat (2) @(negedge clk);
        chk("sb_final_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
